// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared register-file geometry and write-back requester indices
package rf_wb_arbiter_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;
   localparam int RF_NREG   = 32;

   localparam int WB_ALU = 0;
   localparam int WB_LD  = 1;
   localparam int WB_MD  = 2;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting from a priority pointer
module rr_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter  int N  = 3,
   localparam int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any_gnt
);

   int idx;

   // Scan ptr, ptr+1, ... modulo N and take the first requester found.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any_gnt && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            any_gnt  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port scheduler with pending-register scoreboard
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]      rf_a3,
   output logic [DATA_W-1:0]      rf_dw,
   output logic                   rf_enable,
   input  logic                   rsv_valid,
   input  logic [ADDR_W-1:0]      rsv_addr,
   input  logic [ADDR_W-1:0]      q_a1,
   input  logic [ADDR_W-1:0]      q_a2,
   output logic                   q_busy1,
   output logic                   q_busy2,
   output logic [2**ADDR_W-1:0]   sb_busy
);

   localparam int PW   = ptr_w(NREQ);
   localparam int NREG = 2**ADDR_W;

   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] live_req;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            any_gnt;
   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_next;

   // Requests are invisible while reset is held so nothing is granted or written.
   assign live_req = reset ? '0 : req_valid;

   rr_arbiter #(.N(NREQ)) u_rr_arbiter (
      .req     (live_req),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   assign req_ready = gnt;
   assign rf_enable = any_gnt;

   // One-hot AND-OR select keeps the write port at zero when nothing is granted.
   always_comb begin
      rf_a3 = '0;
      rf_dw = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            rf_a3 = rf_a3 | req_addr[i*ADDR_W +: ADDR_W];
            rf_dw = rf_dw | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

   // Reservation is applied after the commit clear so a new owner keeps the bit set.
   always_comb begin
      sb_next = sb;
      if (rf_enable) begin
         sb_next[rf_a3] = 1'b0;
      end
      if (rsv_valid && rsv_addr != '0) begin
         sb_next[rsv_addr] = 1'b1;
      end
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb <= '0;
      end else begin
         sb <= sb_next;
      end
   end

   assign q_busy1 = sb[q_a1];
   assign q_busy2 = sb[q_a2];
   assign sb_busy = sb;

endmodule
